// File: rtl/g3f_pkg.sv
// Shared types, phase constants and reset defaults for the g3f phase sequencer.
package g3f_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam logic [2:0] PhA = 3'b001;
  localparam logic [2:0] PhB = 3'b010;
  localparam logic [2:0] PhC = 3'b100;

  localparam logic [2:0]  PhReset     = PhA;
  localparam logic        DirReset    = 1'b0;
  localparam int unsigned PeriodReset = 1;
  localparam int unsigned DtReset     = 0;

  // Forward rotates a->b->c (shift up), reverse rotates a->c->b (shift down).
  function automatic logic [2:0] rot(input logic [2:0] ph, input logic dir);
    return dir ? {ph[0], ph[2:1]} : {ph[1:0], ph[2]};
  endfunction

endpackage

// File: rtl/g3f_div.sv
// Step-period counter: counts 0..period_eff-1 while enabled and flags the terminal count.
module g3f_div #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] period_eff_i,
  output logic             tc_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == period_eff_i - DIV_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/g3f_seq_ctrl.sv
// Three-phase sequencer: one-hot phase ring, dead-time gated drives, start/stop FSM.
// Optional fault input/sticky flag enabled by defining G3F_FAULT_EN.
module g3f_seq_ctrl
  import g3f_pkg::*;
#(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned DT_W  = 4
) (
  input  logic             SE,
  input  logic             RST,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [DIV_W-1:0] CFG_PERIOD,
  input  logic [DT_W-1:0]  CFG_DT,
  input  logic             CFG_DIR,
  input  logic             START,
  input  logic             STOP,
`ifdef G3F_FAULT_EN
  input  logic             FAULT,
  output logic             FAULTED,
`endif
  output logic             Qa,
  output logic             Qb,
  output logic             Qc,
  output logic             P0,
  output logic             P1,
  output logic             P2,
  output logic             STEP,
  output logic             BUSY
);

  localparam int unsigned CmpW = (DIV_W > DT_W) ? DIV_W : DT_W;

  state_e           state_q;
  logic [2:0]       ph_q;
  logic [DT_W-1:0]  dtc_q, dt_q, dt_eff;
  logic [DIV_W-1:0] period_q, period_eff, period_m1;
  logic             dir_q, step_q;
  logic             tc, start_go, cfg_accept, fault, faulted;

  assign period_eff = (period_q == '0) ? DIV_W'(1) : period_q;
  assign period_m1  = period_eff - DIV_W'(1);
  // Clamp leaves at least one driven cycle per step.
  assign dt_eff = (CmpW'(dt_q) > CmpW'(period_m1)) ? DT_W'(period_m1) : dt_q;

  assign cfg_accept = CFG_VALID && (state_q == StIdle);
  assign start_go   = (state_q == StIdle) && START && !STOP && !faulted;

`ifdef G3F_FAULT_EN
  logic faulted_q;
  assign fault   = FAULT;
  assign faulted = faulted_q;
  assign FAULTED = faulted_q;

  always_ff @(posedge SE) begin
    if (RST) begin
      faulted_q <= 1'b0;
    end else if (FAULT) begin
      faulted_q <= 1'b1;
    end else if (cfg_accept) begin
      faulted_q <= 1'b0;
    end
  end
`else
  assign fault   = 1'b0;
  assign faulted = 1'b0;
`endif

  g3f_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk_i       (SE),
    .rst_i       (RST),
    .clr_i       (start_go),
    .en_i        (state_q != StIdle),
    .period_eff_i(period_eff),
    .tc_o        (tc)
  );

  always_ff @(posedge SE) begin
    if (RST) begin
      state_q  <= StIdle;
      ph_q     <= PhReset;
      dtc_q    <= '0;
      dt_q     <= DT_W'(DtReset);
      period_q <= DIV_W'(PeriodReset);
      dir_q    <= DirReset;
      step_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (dtc_q != '0) begin
        dtc_q <= dtc_q - DT_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (cfg_accept) begin
            period_q <= CFG_PERIOD;
            dt_q     <= CFG_DT;
            dir_q    <= CFG_DIR;
          end
          if (start_go) begin
            state_q <= StRun;
            dtc_q   <= dt_eff;
          end
        end
        StRun: begin
          if (tc) begin
            ph_q   <= rot(ph_q, dir_q);
            step_q <= 1'b1;
            dtc_q  <= dt_eff;
          end
          if (STOP) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (tc) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (fault) begin
        state_q <= StIdle;
        step_q  <= 1'b0;
      end
    end
  end

  assign BUSY      = (state_q != StIdle);
  assign CFG_READY = (state_q == StIdle);
  assign STEP      = step_q;
  assign {Qc, Qb, Qa} = ph_q;
  assign {P2, P1, P0} = (BUSY && (dtc_q == '0)) ? ph_q : 3'b000;

endmodule

// File: doc/g3f_seq_ctrl.md
# g3f_seq_ctrl

Sequencer controller for the three-phase generator: produces the one-hot phase ring (Qa/Qb/Qc) at a programmable step rate and direction, and gated drive outputs (P0/P1/P2) with dead-time between phases. Sits upstream of the phase drivers. A start/stop state machine and a config handshake control it, replacing free-running rotation on every SE edge.

## Interface
Parameters:
- DIV_W, 16, width of step-period register and divider counter
- DT_W, 4, width of dead-time register and counter

Ports:
- SE  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- CFG_VALID  in  1  config word valid
- CFG_READY  out  1  config accepted this cycle when VALID&READY
- CFG_PERIOD  in  DIV_W  step period in SE cycles
- CFG_DT  in  DT_W  dead-time in SE cycles after each phase change
- CFG_DIR  in  1  0 = forward a→b→c→a, 1 = reverse a→c→b→a
- START  in  1  level, sampled each edge
- STOP  in  1  level, sampled each edge
- Qa, Qb, Qc  out  1 each  raw one-hot phase ring
- P0, P1, P2  out  1 each  gated drive for phases a, b, c
- STEP  out  1  one-cycle pulse on each phase advance
- BUSY  out  1  high in RUN or DRAIN

## Operation
- Registers: ph[2:0] one-hot, cnt (DIV_W), dtc (DT_W), period, dt, dir, FSM state
- Reset values: ph=001 (Qa=1, Qb=Qc=0), P=000, STEP=0, BUSY=0, CFG_READY=1, period=1, dt=0, dir=0, cnt=0, dtc=0, state IDLE
- FSM states:
  - IDLE: CFG_READY=1; VALID&READY latches period, dt, dir. START with STOP low → RUN, with cnt=0 and dtc=dt_eff.
  - RUN: cnt increments each cycle. When cnt==period_eff−1, the next edge sets cnt=0, rotates ph per dir, sets STEP=1, and sets dtc=dt_eff. STOP → DRAIN.
  - DRAIN: continues counting. At terminal count → IDLE, with no rotation and no STEP.
- CFG_READY=0 in RUN and DRAIN; CFG_VALID is ignored there and is not queued.
- period_eff = max(period,1); dt_eff = min(dt, period_eff−1), which guarantees at least one driven cycle per step.
- dtc decrements while nonzero.
- P = ph when state ∈ {RUN, DRAIN} and dtc==0; otherwise 000. At most one P bit high, ever.
- Qa/Qb/Qc = ph in all states. ph holds its value through IDLE, so a restart resumes from the last phase.
- Boundary rules:
  - START & STOP in the same cycle: STOP wins; IDLE stays IDLE.
  - START in RUN/DRAIN: ignored.
  - STOP in IDLE: ignored.
  - STOP in the terminal-count cycle of RUN: the rotation for that step still occurs, then the FSM enters DRAIN and a full period follows.
  - cnt wrap: never exceeds period_eff−1.
  - period=1 (period_eff=1), dt=0: rotation every cycle in RUN, STEP continuously high.
  - RST mid-operation: all registers return to reset values at that edge, including ph=001 and the config.

## Timing
- Config: latched at the edge where VALID&READY=1; effective from the next START.
- START sampled at edge k: BUSY=1 from k+1; P=000 for cycles k+1..k+dt_eff; first P active at k+1+dt_eff.
- First STEP pulse at edge k+period_eff, then every period_eff cycles.
- P deasserts in the same cycle ph rotates, because dtc is reloaded at that edge.
- DRAIN → IDLE: BUSY and P fall at the edge following the terminal count.
- Outputs are registered or single-level decodes of registers; no input-to-output combinational paths.

## Configuration
- G3F_FAULT_EN defined:
  - Adds input FAULT (1) and output FAULTED (1).
  - FAULT high at any edge: next state IDLE, P=000, FAULTED=1.
  - FAULTED is sticky until RST or an accepted config.
  - START is ignored while FAULTED=1.
  - FAULTED reset value is 0.
- G3F_FAULT_EN undefined: the ports and logic are absent; behaviour is exactly as above.

## Structure
- g3f_pkg holds:
  - state enum {IDLE, RUN, DRAIN}
  - phase constants PH_A=001, PH_B=010, PH_C=100
  - rotation function rot(ph, dir)
  - default reset constants
- One sub-module, g3f_div: period counter with terminal-count output, cleared on start, parameter DIV_W.
- Dead-time counter and FSM live in the top module.

## Test plan
- Reset: assert RST 2 cycles → Qa..Qc=100, P=000, STEP=0, BUSY=0, CFG_READY=1.
- Forward run: config period=4, dt=1, dir=0; START 1 cycle → STEP every 4 cycles; Qa→Qb→Qc→Qa; each P low 1 cycle after rotation, then high 3 cycles.
- Reverse and clamping: period=3, dt=7, dir=1 → dt_eff=2; rotation a→c→b; P high exactly 1 cycle per step.
- Stop/drain and simultaneous events:
  - STOP mid-step in RUN → no further STEP; BUSY falls after the current period completes.
  - START & STOP together in IDLE → BUSY stays 0.
- Config gating and reset mid-run:
  - CFG_VALID during RUN with period=9 → CFG_READY=0; period is unchanged after restart.
  - RST during RUN → all outputs return to reset values next cycle.
- With G3F_FAULT_EN: FAULT pulse in RUN → P=000 and BUSY=0 next cycle, FAULTED=1; START ignored; accepted config clears FAULTED.
